mem_store_unit: RTL and testbench

Write-side companion to the instruction/data memory read path. It accepts store requests (address from AR, data from the common bus) through a valid/ready handshake and holds them in a small FIFO. It then drains them to the memory write port, one strobed write at a time, with a mandatory low gap between strobes. It sits between the bus/control sequencer and the 16-word memory, so the sequencer never stalls on memory write timing unless the buffer is full.

---
 rtl/store_pkg.sv | 20 ++
 rtl/store_fifo.sv | 57 +++++
 rtl/mem_store_unit.sv | 145 ++++++++++++++
 tb/tb_mem_store_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and default sizing for the memory store path.
package store_pkg;

    localparam int ST_DEPTH     = 4;
    localparam int ST_AW        = 12;
    localparam int ST_DW        = 16;
    localparam int ST_MEM_WORDS = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } st_state_t;

    typedef struct packed {
        logic [ST_AW-1:0] addr;
        logic [ST_DW-1:0] data;
    } st_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Store buffer: circular entry storage with occupancy count.
// Also presents every slot in age order (oldest first) for the forwarding search.
module store_fifo
    import store_pkg::*;
#(
    parameter int DEPTH = ST_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  st_entry_t                push_entry,
    input  logic                     pop,
    output st_entry_t                head,
    output st_entry_t                age_entries [DEPTH],
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    st_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entries[i] = mem[rd_ptr + PW'(i)];
        end
    end

endmodule

// File: rtl/mem_store_unit.sv
// Buffers store requests and drains them as single strobed memory writes with a gap cycle.
// Optional STORE_FWD_EN adds a youngest-match forwarding lookup over buffered stores.
//
//   state   | meaning
//   S_IDLE  | buffer empty, no write in flight
//   S_ISSUE | head presented on mem_addr/mem_wdata; strobe high until mem_busy=0
//   S_GAP   | mandatory one-cycle low gap after a completed write
module mem_store_unit
    import store_pkg::*;
#(
    parameter int DEPTH     = ST_DEPTH,
    parameter int AW        = ST_AW,
    parameter int DW        = ST_DW,
    parameter int MEM_WORDS = ST_MEM_WORDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [AW-1:0]           st_addr,
    input  logic [DW-1:0]           st_data,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic                    mem_busy,
    input  logic                    err_clr,
    output logic                    err_range,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    empty,
    input  logic [AW-1:0]           fwd_addr,
    output logic                    fwd_hit,
    output logic [DW-1:0]           fwd_data
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_WORDS);

    st_state_t  state, state_next;
    st_entry_t  head;
    st_entry_t  push_entry;
    st_entry_t  age_entries [DEPTH];
    logic       fifo_full, fifo_empty;
    logic       accept, in_range, push, pop, load, we_next;

    assign st_ready         = !fifo_full;
    assign accept           = st_valid && st_ready;
    assign in_range         = (st_addr < MEM_LIMIT);
    assign push             = accept && in_range;
    assign push_entry.addr  = st_addr;
    assign push_entry.data  = st_data;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .age_entries (age_entries),
        .count       (pending),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_we && !mem_busy) begin
                    pop        = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Leaving IDLE, address/data settle for one cycle before the first strobe.
        we_next = (state_next == S_ISSUE) && (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_next;
            mem_we <= we_next;
            if (load) begin
                mem_addr  <= head.addr;
                mem_wdata <= head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    err_range <= 1'b0;
        else if (accept && !in_range)  err_range <= 1'b1;
        else if (err_clr)              err_range <= 1'b0;
    end

    assign empty = (pending == '0) && (state == S_IDLE);

`ifdef STORE_FWD_EN
    // Ascending age scan: the last (youngest) valid match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < pending) && (age_entries[i].addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = age_entries[i].data;
            end
        end
    end
`else
    logic fwd_unused;

    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;

    always_comb begin
        fwd_unused = ^fwd_addr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_unused = fwd_unused ^ (^age_entries[i]);
        end
    end
`endif

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: latency, ordering, stalls, range errors, forwarding, reset.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [11:0] st_addr;
    logic [15:0] st_data;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_busy;
    logic        err_clr;
    logic        err_range;
    logic [2:0]  pending;
    logic        empty;
    logic [11:0] fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [11:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q  [$];

    mem_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_busy  (mem_busy),
        .err_clr   (err_clr),
        .err_range (err_range),
        .pending   (pending),
        .empty     (empty),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    // Logs every completed write (strobe high, memory not stalled).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && mem_we && !mem_busy) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_addr_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 32'(wr_addr_q.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        mem_busy = 1'b0;
        err_clr  = 1'b0;
        fwd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_st_ready",  32'(st_ready),  1);
        check_eq("rst_mem_we",    32'(mem_we),    0);
        check_eq("rst_mem_addr",  32'(mem_addr),  0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
        check_eq("rst_err_range", 32'(err_range), 0);
        check_eq("rst_pending",   32'(pending),   0);
        check_eq("rst_empty",     32'(empty),     1);
        check_eq("rst_fwd_hit",   32'(fwd_hit),   0);
        rst_n = 1'b1;
        step();

        // Single store: strobe appears two edges after accept, lasts one cycle.
        clear_log();
        st_valid = 1'b1; st_addr = 12'd3; st_data = 16'hA5A5;
        step();
        st_valid = 1'b0;
        check_eq("s1_pending_n0", 32'(pending), 1);
        check_eq("s1_we_n0",      32'(mem_we),  0);
        step();
        check_eq("s1_we_n1",      32'(mem_we),  0);
        step();
        check_eq("s1_we_n2",      32'(mem_we),    1);
        check_eq("s1_addr_n2",    32'(mem_addr),  3);
        check_eq("s1_data_n2",    32'(mem_wdata), 32'hA5A5);
        step();
        check_eq("s1_we_n3",      32'(mem_we),  0);
        check_eq("s1_pending_n3", 32'(pending), 0);
        step();
        check_eq("s1_empty",      32'(empty),   1);
        check_eq("s1_writes",     32'(wr_addr_q.size()), 1);

        // Fill the buffer while memory stalls, then drain in order.
        clear_log();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 12'(i); st_data = 16'h1000 + 16'(i);
            step();
            check_eq($sformatf("s2_ready_after_%0d", i), 32'(st_ready), (i < 3) ? 1 : 0);
        end
        st_addr = 12'd4; st_data = 16'h1004;
        step();
        step();
        check_eq("s2_pending_full", 32'(pending),  4);
        check_eq("s2_ready_full",   32'(st_ready), 0);
        check_eq("s2_we_stalled",   32'(mem_we),   1);
        mem_busy = 1'b0;
        for (int k = 0; k < 10 && !st_ready; k++) step();
        check_eq("s2_ready_back", 32'(st_ready), 1);
        step();
        st_valid = 1'b0;
        wait_writes("s2_writes", 5, 40);
        repeat (4) step();
        check_eq("s2_no_extra", 32'(wr_addr_q.size()), 5);
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            check_eq($sformatf("s2_addr_%0d", i), 32'(wr_addr_q[i]), 32'(i));
            check_eq($sformatf("s2_data_%0d", i), 32'(wr_data_q[i]), 32'h1000 + 32'(i));
            if (i > 0)
                check_eq($sformatf("s2_spacing_%0d", i), 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 2);
        end
        check_eq("s2_empty", 32'(empty), 1);

        // Stall during ISSUE: strobe and payload hold, one write completes.
        clear_log();
        mem_busy = 1'b1;
        st_valid = 1'b1; st_addr = 12'd7; st_data = 16'h0777;
        step();
        st_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("s3_we_%0d", k),   32'(mem_we),    1);
            check_eq($sformatf("s3_addr_%0d", k), 32'(mem_addr),  7);
            check_eq($sformatf("s3_data_%0d", k), 32'(mem_wdata), 32'h0777);
            if (k < 2) step();
        end
        mem_busy = 1'b0;
        step();
        check_eq("s3_we_done", 32'(mem_we), 0);
        repeat (4) step();
        check_eq("s3_writes", 32'(wr_addr_q.size()), 1);

        // Highest in-range address is written.
        clear_log();
        st_valid = 1'b1; st_addr = 12'h00F; st_data = 16'h5A5A;
        step();
        st_valid = 1'b0;
        check_eq("s4_edge_err", 32'(err_range), 0);
        wait_writes("s4_edge_writes", 1, 10);
        if (wr_addr_q.size() > 0) check_eq("s4_edge_addr", 32'(wr_addr_q[0]), 32'h00F);
        repeat (3) step();

        // First out-of-range address: accepted, dropped, flagged.
        clear_log();
        st_valid = 1'b1; st_addr = 12'h010; st_data = 16'hBEEF;
        step();
        st_valid = 1'b0;
        check_eq("s4_err_set",     32'(err_range), 1);
        check_eq("s4_bad_pending", 32'(pending),   0);
        repeat (5) step();
        check_eq("s4_bad_writes",  32'(wr_addr_q.size()), 0);
        check_eq("s4_err_sticky",  32'(err_range), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("s4_err_clr",     32'(err_range), 0);
        err_clr = 1'b1; st_valid = 1'b1; st_addr = 12'hFFF;
        step();
        err_clr = 1'b0; st_valid = 1'b0;
        check_eq("s4_set_wins",    32'(err_range), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Forwarding lookup over stalled stores.
        clear_log();
        mem_busy = 1'b1;
        st_valid = 1'b1; st_addr = 12'd5; st_data = 16'h0001;
        step();
        st_data = 16'h0002;
        step();
        st_addr = 12'd6; st_data = 16'h0003;
        step();
        st_valid = 1'b0;
        fwd_addr = 12'd5;
        #1;
`ifdef STORE_FWD_EN
        check_eq("s5_hit5",  32'(fwd_hit),  1);
        check_eq("s5_data5", 32'(fwd_data), 2);
        fwd_addr = 12'd6;
        #1;
        check_eq("s5_hit6",  32'(fwd_hit),  1);
        check_eq("s5_data6", 32'(fwd_data), 3);
        fwd_addr = 12'd9;
        #1;
        check_eq("s5_miss9", 32'(fwd_hit),  0);
`else
        check_eq("s5_hit_off",  32'(fwd_hit),  0);
        check_eq("s5_data_off", 32'(fwd_data), 0);
`endif
        mem_busy = 1'b0;
        wait_writes("s5_writes", 3, 20);
        repeat (3) step();
        fwd_addr = 12'd5;
        #1;
        check_eq("s5_hit_after", 32'(fwd_hit), 0);
        for (int i = 0; i < 3 && i < wr_data_q.size(); i++)
            check_eq($sformatf("s5_order_%0d", i), 32'(wr_data_q[i]), 32'(i + 1));

        // Asynchronous reset mid-drain discards everything.
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 12'd8 + 12'(i); st_data = 16'h0800 + 16'(i);
            step();
        end
        st_valid = 1'b0;
        for (int k = 0; k < 10 && !mem_we; k++) step();
        check_eq("s6_we_before",      32'(mem_we),  1);
        check_eq("s6_pending_before", 32'(pending), 3);
        rst_n = 1'b0;
        #1;
        check_eq("s6_we_async",      32'(mem_we),   0);
        check_eq("s6_pending_async", 32'(pending),  0);
        check_eq("s6_ready_async",   32'(st_ready), 1);
        step();
        step();
        rst_n    = 1'b1;
        mem_busy = 1'b0;
        clear_log();
        repeat (8) step();
        check_eq("s6_writes_after", 32'(wr_addr_q.size()), 0);
        check_eq("s6_pending_after", 32'(pending), 0);
        check_eq("s6_empty_after",   32'(empty),   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
